// File: rtl/ft600_responder.sv
// FT600-style 245 synchronous FIFO bus responder: load port -> RFIFO -> bus reads, bus writes -> WFIFO -> drain port.
// Latency: ad_out/out_data show FIFO heads combinationally; rxf_n, txe_n and ad_oe are registered (one cycle behind).
// Backpressure: in_ready drops when RFIFO is full; bus writes into a full WFIFO are dropped and flagged; out_valid/out_ready drain.
//
// Ports:
//   CLK, nRST                      bus clock, synchronous active-low reset
//   rxf_n, txe_n                   bus status (RFIFO has data / WFIFO has space), active-low
//   rd_n, wr_n, oe_n, ad_in        initiator strobes and write data
//   ad_out, ad_oe                  read data and its tristate enable (IOBUF lives at the top level)
//   in_valid/in_ready/in_data      load port into the RFIFO
//   out_valid/out_ready/out_data   drain port out of the WFIFO
//   err_underrun/overflow/contention, err_clr   sticky protocol-error flags and their clear
// Optional: define FT600_RESPONDER_ERRCNT_EN to add err_count[7:0], a saturating per-cycle error-event counter.

// Generic synchronous FIFO used for both directions; head word is shown combinationally.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty.
module ft600_responder_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers are AW bits wide so they wrap modulo the depth on their own.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    // The count never exceeds the depth, so its top bit alone means full.
    assign full     = count[AW];
    assign empty    = (count == '0);
endmodule

module ft600_responder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DW         = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    output logic          rxf_n,
    output logic          txe_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          oe_n,
    input  logic [DW-1:0] ad_in,
    output logic [DW-1:0] ad_out,
    output logic          ad_oe,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          err_underrun,
    output logic          err_overflow,
    output logic          err_contention,
    input  logic          err_clr
`ifdef FT600_RESPONDER_ERRCNT_EN
    ,
    output logic [7:0]    err_count
`endif
);
    logic [DEPTH_LOG2:0] rf_count;
    logic [DEPTH_LOG2:0] wf_count;
    logic                rf_full;
    logic                rf_empty;
    logic                wf_full;
    logic                wf_empty;
    logic                contention_ev;
    logic                underrun_ev;
    logic                overflow_ev;
    logic                rd_beat;
    logic                wr_beat;
    logic                load_push;
    logic                drain_pop;

    // A write strobe together with either read-side strobe is an illegal bus
    // state: nothing moves on the bus in that cycle.
    assign contention_ev = !wr_n && (!oe_n || !rd_n);
    assign underrun_ev   = !rd_n && rf_empty;
    assign overflow_ev   = !wr_n && wf_full;
    assign rd_beat       = !rd_n && !oe_n && !rf_empty && !contention_ev;
    assign wr_beat       = !wr_n &&  oe_n && !wf_full  && !contention_ev;
    assign load_push     = in_valid && !rf_full;
    assign drain_pop     = out_ready && !wf_empty;

    assign in_ready  = !rf_full;
    assign out_valid = !wf_empty;

    ft600_responder_fifo #(.DW(DW), .AW(DEPTH_LOG2)) u_rfifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (load_push),
        .push_dat (in_data),
        .pop      (rd_beat),
        .head_dat (ad_out),
        .count    (rf_count),
        .full     (rf_full),
        .empty    (rf_empty)
    );

    ft600_responder_fifo #(.DW(DW), .AW(DEPTH_LOG2)) u_wfifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (wr_beat),
        .push_dat (ad_in),
        .pop      (drain_pop),
        .head_dat (out_data),
        .count    (wf_count),
        .full     (wf_full),
        .empty    (wf_empty)
    );

    // Status flags lag the FIFOs by one edge; ad_oe lag gives the bus a
    // turnaround cycle before this block drives it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rxf_n <= 1'b1;
            txe_n <= 1'b0;
            ad_oe <= 1'b0;
        end else begin
            rxf_n <= rf_empty;
            txe_n <= wf_full;
            ad_oe <= !oe_n;
        end
    end

    // A new event beats a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            err_underrun   <= 1'b0;
            err_overflow   <= 1'b0;
            err_contention <= 1'b0;
        end else begin
            err_underrun   <= underrun_ev   || (err_underrun   && !err_clr);
            err_overflow   <= overflow_ev   || (err_overflow   && !err_clr);
            err_contention <= contention_ev || (err_contention && !err_clr);
        end
    end

`ifdef FT600_RESPONDER_ERRCNT_EN
    logic any_ev;
    assign any_ev = underrun_ev || overflow_ev || contention_ev;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            err_count <= 8'd0;
        end else if (err_clr) begin
            err_count <= {7'd0, any_ev};
        end else if (any_ev && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    // Occupancy counts are kept for visibility in simulation/debug.
    logic unused_counts;
    assign unused_counts = ^{rf_count, wf_count};
endmodule

// File: tb/tb_ft600_responder.sv
module tb_ft600_responder;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          nRST, rd_n, wr_n, oe_n, in_valid, out_ready, err_clr;
    logic [DW-1:0] ad_in, in_data;
    logic          rxf_n, txe_n, ad_oe, in_ready, out_valid;
    logic          err_underrun, err_overflow, err_contention;
    logic [DW-1:0] ad_out, out_data;
`ifdef FT600_RESPONDER_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    ft600_responder #(.DEPTH_LOG2(4), .DW(DW)) dut (
        .CLK(CLK), .nRST(nRST), .rxf_n(rxf_n), .txe_n(txe_n),
        .rd_n(rd_n), .wr_n(wr_n), .oe_n(oe_n), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_underrun(err_underrun), .err_overflow(err_overflow),
        .err_contention(err_contention), .err_clr(err_clr)
`ifdef FT600_RESPONDER_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: two queues and sticky flags ----------------
    logic [DW-1:0] rq[$];
    logic [DW-1:0] wq[$];
    logic m_rxf_n, m_txe_n, m_ad_oe, m_under, m_over, m_cont;
    int   m_cnt;
    bit   m_live = 0;

    always @(posedge CLK) begin
        int rs, ws;
        bit cont, under, over, rpop, wpush, lpush, dpop, any;
        if (!nRST) begin
            rq.delete(); wq.delete();
            m_rxf_n = 1; m_txe_n = 0; m_ad_oe = 0;
            m_under = 0; m_over = 0; m_cont = 0; m_cnt = 0;
            m_live  = 1;
        end else begin
            rs    = rq.size();
            ws    = wq.size();
            cont  = !wr_n && (!oe_n || !rd_n);
            under = !rd_n && rs == 0;
            over  = !wr_n && ws == DEPTH;
            rpop  = !rd_n && !oe_n && rs > 0 && !cont;
            wpush = !wr_n && oe_n && ws < DEPTH && !cont;
            lpush = in_valid && rs < DEPTH;
            dpop  = out_ready && ws > 0;
            any   = cont || under || over;
            m_rxf_n = (rs == 0);
            m_txe_n = (ws == DEPTH);
            m_ad_oe = !oe_n;
            m_under = under || (m_under && !err_clr);
            m_over  = over  || (m_over  && !err_clr);
            m_cont  = cont  || (m_cont  && !err_clr);
            if (err_clr) m_cnt = any ? 1 : 0;
            else if (any && m_cnt < 255) m_cnt++;
            if (rpop)  void'(rq.pop_front());
            if (lpush) rq.push_back(in_data);
            if (dpop)  void'(wq.pop_front());
            if (wpush) wq.push_back(ad_in);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (m_live) begin
            check("rxf_n", rxf_n, m_rxf_n);
            check("txe_n", txe_n, m_txe_n);
            check("ad_oe", ad_oe, m_ad_oe);
            check("err_underrun", err_underrun, m_under);
            check("err_overflow", err_overflow, m_over);
            check("err_contention", err_contention, m_cont);
            check("in_ready", in_ready, rq.size() < DEPTH);
            check("out_valid", out_valid, wq.size() != 0);
            if (wq.size() != 0) check("out_data", out_data, wq[0]);
            if (rq.size() != 0) check("ad_out", ad_out, rq[0]);
`ifdef FT600_RESPONDER_ERRCNT_EN
            check("err_count", err_count, m_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        rd_n = 1; wr_n = 1; oe_n = 1; in_valid = 0; out_ready = 0; err_clr = 0;
    endtask

    task automatic clear_errs();
        err_clr = 1;
        step();
        err_clr = 0;
    endtask

    logic [DW-1:0] exp3 [3];

    initial begin
        int lk, rk, wk, dk, cyc;
        bit last_bus;
        exp3[0] = 16'h1111; exp3[1] = 16'h2222; exp3[2] = 16'h3333;
        nRST = 0; ad_in = '0; in_data = '0;
        idle();
        repeat (3) step();
        nRST = 1;
        check("rst_rxf_n", rxf_n, 1);
        check("rst_txe_n", txe_n, 0);
        check("rst_ad_oe", ad_oe, 0);
        check("rst_errs", {err_underrun, err_overflow, err_contention}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);

        // Load three words, then read them over the bus.
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = exp3[i];
            step();
        end
        in_valid = 0;
        check("rxf_n_after_load", rxf_n, 0);
        oe_n = 0;
        check("ad_oe_before_turn", ad_oe, 0);
        step();
        check("ad_oe_after_turn", ad_oe, 1);
        rd_n = 0;
        for (int i = 0; i < 3; i++) begin
            check("read_beat_data", ad_out, exp3[i]);
            step();
        end
        rd_n = 1; oe_n = 1;
        check("rxf_n_at_last_pop", rxf_n, 0);
        step();
        check("rxf_n_after_last_pop", rxf_n, 1);
        check("no_underrun_on_reads", err_underrun, 0);

        // Fill the WFIFO with 16 words, overflow with a 17th, drain.
        wr_n = 0;
        for (int i = 0; i < 16; i++) begin
            ad_in = 16'(i);
            step();
        end
        check("txe_n_at_16th_push", txe_n, 0);
        ad_in = 16'h00AA;
        step();
        wr_n = 1;
        check("txe_n_full", txe_n, 1);
        check("overflow_set", err_overflow, 1);
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, 16'(i));
            step();
        end
        out_ready = 0;
        check("dropped_17th", out_valid, 0);
        clear_errs();
        check("overflow_cleared", err_overflow, 0);

        // Underrun, clear, and event-beats-clear.
        rd_n = 0;
        step();
        rd_n = 1;
        check("underrun_set", err_underrun, 1);
        check("underrun_rxf_n", rxf_n, 1);
        check("underrun_no_wdata", out_valid, 0);
        clear_errs();
        check("underrun_cleared", err_underrun, 0);
        rd_n = 0; err_clr = 1;
        step();
        rd_n = 1; err_clr = 0;
        check("event_beats_clear", err_underrun, 1);
        clear_errs();

        // Write strobe with oe_n low: contention, nothing pushed.
        wr_n = 0; oe_n = 0; ad_in = 16'hBEEF;
        step();
        wr_n = 1; oe_n = 1;
        check("contention_set", err_contention, 1);
        check("contention_no_push", out_valid, 0);
        clear_errs();
        check("contention_cleared", err_contention, 0);
        step();

        // Stream 100 words each way with random flow control.
        lk = 0; rk = 0; wk = 0; dk = 0; cyc = 0; last_bus = 0;
        while ((lk < 100 || rk < 100 || wk < 100 || dk < 100) && cyc < 4000) begin
            in_valid  = (lk < 100) && ($urandom_range(0, 3) != 0);
            in_data   = 16'h1000 + 16'(lk);
            out_ready = $urandom_range(0, 1) == 1;
            rd_n = 1; wr_n = 1; oe_n = 1;
            if (!last_bus) begin
                if (rxf_n == 0 && rk < 100 && (wk >= 100 || txe_n == 1 || $urandom_range(0, 1) == 1)) begin
                    rd_n = 0; oe_n = 0;
                end else if (txe_n == 0 && wk < 100) begin
                    wr_n = 0;
                    ad_in = 16'h2000 + 16'(wk);
                end
            end
            if (!rd_n) begin
                check("stream_read", ad_out, 16'h1000 + 16'(rk));
                rk++;
            end
            if (!wr_n) wk++;
            if (out_valid && out_ready) begin
                check("stream_drain", out_data, 16'h2000 + 16'(dk));
                dk++;
            end
            if (in_valid && in_ready) lk++;
            last_bus = !rd_n || !wr_n;
            step();
            cyc++;
        end
        idle();
        check("stream_complete", {rk == 100, dk == 100}, 2'b11);
        check("stream_no_errs", {err_underrun, err_overflow, err_contention}, 0);
        step();
        check("stream_empty", {rxf_n, out_valid}, 2'b10);

        // Reset mid-transfer discards both FIFOs.
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h5000 + 16'(i);
            step();
        end
        in_valid = 0; wr_n = 0;
        for (int i = 0; i < 2; i++) begin
            ad_in = 16'h6000 + 16'(i);
            step();
        end
        wr_n = 1; rd_n = 0;
        step();
        check("pre_reset_loaded", {rxf_n, out_valid}, 2'b01);
        in_valid = 1; in_data = 16'h5555; wr_n = 0; rd_n = 1; nRST = 0;
        step();
        nRST = 1; in_valid = 0; wr_n = 1;
        check("mid_rst_rxf_n", rxf_n, 1);
        check("mid_rst_txe_n", txe_n, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_errs", {err_underrun, err_overflow, err_contention}, 0);
`ifdef FT600_RESPONDER_ERRCNT_EN
        check("mid_rst_err_count", err_count, 0);
`endif
        step();
        check("post_rst_rxf_n", rxf_n, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
